// File: rtl/raytracing_dispatcher_if.sv
// Worker-bank and pixel-stream bundle between the ray dispatcher (master)
// and the worker bank / framebuffer writer side (slave).
interface raytracing_dispatcher_if #(
    parameter int N_WORKERS        = 4,
    parameter int JOBS_SUBDIVISION = 8
);
    logic [N_WORKERS-1:0]                     worker_activate;
    logic signed [N_WORKERS*12-1:0]           worker_x;
    logic signed [11:0]                       worker_y;
    logic [N_WORKERS-1:0]                     worker_busy;
    logic [N_WORKERS*JOBS_SUBDIVISION*12-1:0] worker_buffer;
    logic                                     pix_valid;
    logic                                     pix_ready;
    logic [11:0]                              pix_x;
    logic [11:0]                              pix_y;
    logic [11:0]                              pix_color;
    logic                                     pix_last;

    modport master (
        output worker_activate, worker_x, worker_y,
        input  worker_busy, worker_buffer,
        output pix_valid, pix_x, pix_y, pix_color, pix_last,
        input  pix_ready
    );

    modport slave (
        input  worker_activate, worker_x, worker_y,
        output worker_busy, worker_buffer,
        input  pix_valid, pix_x, pix_y, pix_color, pix_last,
        output pix_ready
    );
endinterface

// File: rtl/raytracing_dispatcher.sv
// Ray worker dispatcher: walks the screen in raster-ordered tiles of
// N_WORKERS*JOBS_SUBDIVISION pixels, launches the worker bank on each tile,
// waits for it to finish, then drains the worker colour buffers as a
// raster-ordered valid/ready pixel stream.
module raytracing_dispatcher #(
    parameter int N_WORKERS        = 4,
    parameter int JOBS_SUBDIVISION = 8,
    parameter int SCREEN_W         = 640,
    parameter int SCREEN_H         = 480
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    raytracing_dispatcher_if.master bus
);
    localparam int TILE_W = N_WORKERS * JOBS_SUBDIVISION;
    localparam int P_W    = $clog2(TILE_W);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, DONE} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [11:0]    tile_x;
    logic [11:0]    row;
    logic [P_W-1:0] drain_idx;
    logic [P_W-1:0] load_idx;
    logic [11:0]    load_x;
    logic [11:0]    tile_color [TILE_W];
    logic           handshake;
    logic           last_hs;
    logic           load;
    logic           more_tiles;
    logic           more_rows;

    // Pixel p of a tile lives in worker p % N_WORKERS, job p / N_WORKERS.
    for (genvar p = 0; p < TILE_W; p++) begin : g_color
        localparam int SEL = (p % N_WORKERS) * JOBS_SUBDIVISION + p / N_WORKERS;
        assign tile_color[p] = bus.worker_buffer[SEL*12 +: 12];
    end

    // Worker w starts its pixel interleave at tile_x + w on the shared row.
    for (genvar w = 0; w < N_WORKERS; w++) begin : g_wx
        assign bus.worker_x[w*12 +: 12] = tile_x + 12'(w);
    end
    assign bus.worker_y        = row;
    assign bus.worker_activate = (state == LAUNCH || state == WAIT) ? '1 : '0;
    assign frame_done          = (state == DONE);

    assign handshake  = bus.pix_valid & bus.pix_ready;
    assign last_hs    = handshake && (drain_idx == P_W'(TILE_W - 1));
    assign more_tiles = ({1'b0, tile_x} + 13'(TILE_W)) < 13'(SCREEN_W);
    assign more_rows  = row < 12'(SCREEN_H - 1);
    // A new pixel is staged on the first drain cycle and after every
    // accepted pixel except the tile's last one.
    assign load       = (state == DRAIN) && (!bus.pix_valid || (handshake && !last_hs));
    assign load_idx   = bus.pix_valid ? drain_idx + P_W'(1) : drain_idx;
    assign load_x     = tile_x + 12'(load_idx);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (bus.worker_busy == '0) state_nxt = DRAIN;
            DRAIN:   if (last_hs) state_nxt = (more_tiles || more_rows) ? LAUNCH : DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame position, drain index and registered pixel stream outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy          <= 1'b0;
            tile_x        <= '0;
            row           <= '0;
            drain_idx     <= '0;
            bus.pix_valid <= 1'b0;
            bus.pix_last  <= 1'b0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.pix_color <= '0;
        end else begin
            if (state == IDLE && start) begin
                busy   <= 1'b1;
                tile_x <= '0;
                row    <= '0;
            end
            if (state == DONE) begin
                busy <= 1'b0;
            end
            if (state == WAIT) begin
                drain_idx <= '0;
            end
            if (load) begin
                bus.pix_valid <= 1'b1;
                bus.pix_x     <= load_x;
                bus.pix_y     <= row;
                bus.pix_color <= tile_color[load_idx];
                bus.pix_last  <= (row == 12'(SCREEN_H - 1)) && (load_x == 12'(SCREEN_W - 1));
            end
            if (handshake) begin
                if (last_hs) begin
                    bus.pix_valid <= 1'b0;
                    bus.pix_last  <= 1'b0;
                    if (more_tiles) begin
                        tile_x <= tile_x + 12'(TILE_W);
                    end else if (more_rows) begin
                        tile_x <= '0;
                        row    <= row + 12'd1;
                    end
                end else begin
                    drain_idx <= drain_idx + P_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_raytracing_dispatcher.sv
// Randomized bench for raytracing_dispatcher on a 64x2 screen with four
// behavioural workers and a raster-order reference pixel queue.
module tb_raytracing_dispatcher;
    localparam int NW     = 4;
    localparam int JS     = 8;
    localparam int SW     = 64;
    localparam int SH     = 2;
    localparam int TILE   = NW * JS;
    localparam int TOTAL  = SW * SH;
    localparam int BUDGET = 20000;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] c;
        logic        last;
    } pix_t;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic frame_done;

    raytracing_dispatcher_if #(.N_WORKERS(NW), .JOBS_SUBDIVISION(JS)) rif ();

    raytracing_dispatcher #(
        .N_WORKERS(NW), .JOBS_SUBDIVISION(JS), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .frame_done(frame_done), .bus(rif)
    );

    int   n_checks;
    int   n_errors;
    int   mode;
    int   ready_pct;
    int   slow_extra;
    bit   mon_en;
    int   hs_count;
    int   fd_cnt;
    bit   held;
    pix_t saved;
    pix_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference frame: every pixel once, raster order, colour by the active worker pattern.
    task automatic build_queue(input int m);
        pix_t e;
        exp_q.delete();
        for (int y = 0; y < SH; y++) begin
            for (int x = 0; x < SW; x++) begin
                int p;
                p = x % TILE;
                e.x = 12'(x);
                e.y = 12'(y);
                if (m == 0) e.c = {6'(x), 6'(y)};
                else        e.c = {4'(p % NW), 4'(p / NW), 4'h0};
                e.last = (x == SW - 1) && (y == SH - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Random downstream readiness, changed away from both clock edges.
    initial begin
        rif.pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            rif.pix_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // Behavioural workers: go busy on activate, fill buffer after a delay, stay done until activate drops.
    initial begin
        bit started [NW];
        int cnt [NW];
        for (int w = 0; w < NW; w++) begin
            started[w] = 1'b0;
            cnt[w]     = 0;
        end
        rif.worker_busy   = '0;
        rif.worker_buffer = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int w = 0; w < NW; w++) begin
                if (!rif.worker_activate[w]) begin
                    started[w] = 1'b0;
                end else if (!started[w]) begin
                    started[w]         = 1'b1;
                    rif.worker_busy[w] = 1'b1;
                    cnt[w] = 6 + int'($urandom_range(0, 2)) + ((w == NW - 1) ? slow_extra : 0);
                end else if (rif.worker_busy[w]) begin
                    cnt[w]--;
                    if (cnt[w] == 0) begin
                        for (int j = 0; j < JS; j++) begin
                            logic [11:0] xv;
                            logic [11:0] col;
                            xv = rif.worker_x[w*12 +: 12] + 12'(j * NW);
                            if (mode == 0) col = {xv[5:0], rif.worker_y[5:0]};
                            else           col = {4'(w), 4'(j), 4'h0};
                            rif.worker_buffer[(w*JS + j)*12 +: 12] = col;
                        end
                        rif.worker_busy[w] = 1'b0;
                    end
                end
            end
        end
    end

    // Stream monitor: order, content, stall stability and waiting behaviour.
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (mon_en) begin
            if (rif.worker_busy != '0) begin
                chk("wait_no_valid", rif.pix_valid, 0);
                chk("wait_activate", rif.worker_activate, 32'hF);
            end
            if (held) begin
                chk("hold_valid", rif.pix_valid, 1);
                chk("hold_x", rif.pix_x, saved.x);
                chk("hold_y", rif.pix_y, saved.y);
                chk("hold_color", rif.pix_color, saved.c);
                chk("hold_last", rif.pix_last, saved.last);
            end
            if (rif.pix_valid && rif.pix_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_pixel", hs_count + 1, TOTAL);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    chk("pix_x", rif.pix_x, e.x);
                    chk("pix_y", rif.pix_y, e.y);
                    chk("pix_color", rif.pix_color, e.c);
                    chk("pix_last", rif.pix_last, e.last);
                end
                hs_count++;
            end
            held       = rif.pix_valid && !rif.pix_ready;
            saved.x    = rif.pix_x;
            saved.y    = rif.pix_y;
            saved.c    = rif.pix_color;
            saved.last = rif.pix_last;
            if (frame_done) begin
                chk("busy_at_done", busy, 1);
                chk("done_after_last", hs_count, TOTAL);
            end
        end
    end

    task automatic run_frame(input int m, input int rp, input int slow, input bit poke);
        int cyc;
        mode       = m;
        ready_pct  = rp;
        slow_extra = slow;
        build_queue(m);
        hs_count = 0;
        fd_cnt   = 0;
        held     = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_started", busy, 1);
        cyc = 0;
        while (fd_cnt == 0 && cyc < BUDGET) begin
            @(negedge clk);
            start = poke && busy && (cyc % 97 == 50);
            cyc++;
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pixel_count", hs_count, TOTAL);
        chk("done_pulses", fd_cnt, 1);
        chk("busy_after", busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_valid"}, rif.pix_valid, 0);
        chk({tag, "_last"}, rif.pix_last, 0);
        chk({tag, "_act"}, rif.worker_activate, 0);
        chk({tag, "_px"}, rif.pix_x, 0);
        chk({tag, "_py"}, rif.pix_y, 0);
        chk({tag, "_pc"}, rif.pix_color, 0);
    endtask

    initial begin
        int cyc;
        n_checks   = 0;
        n_errors   = 0;
        mode       = 0;
        ready_pct  = 100;
        slow_extra = 0;
        mon_en     = 1'b0;
        hs_count   = 0;
        fd_cnt     = 0;
        held       = 1'b0;
        rst_n      = 1'b0;
        start      = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        run_frame(0, 100, 0, 1'b0);
        run_frame(1, 100, 0, 1'b0);
        run_frame(0, 30, 0, 1'b0);
        run_frame(0, 100, 50, 1'b0);

        // Reset in the middle of the first tile's drain.
        mode      = 0;
        ready_pct = 100;
        build_queue(0);
        hs_count = 0;
        fd_cnt   = 0;
        held     = 1'b0;
        mon_en   = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (hs_count < 10 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        chk("reached_pixel10", hs_count >= 10, 1);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_no_done", fd_cnt, 0);
        run_frame(0, 60, 0, 1'b0);

        // Start pulses while busy must not disturb the frame.
        run_frame(1, 50, 0, 1'b1);

        // Start coincident with reset: reset wins.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_in_reset_busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("start_in_reset_idle", busy, 0);
        chk("start_in_reset_act", rif.worker_activate, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
